// File: rtl/io_bus_pkg.sv
// Shared widths and types for the peripheral I/O bus arbiter.
package io_bus_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        WDRIVE,
        WSTROBE,
        WHOLD,
        DONE,
        RECOVER
    } state_t;

    typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not granted last.
module rr_arbiter2
    import io_bus_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last_grant,
    output logic       grant_valid,
    output req_idx_t   grant_idx
);

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared 8-bit peripheral I/O bus.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int unsigned RECOVER_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] a3_a0,
    inout  wire  [DATA_W-1:0] d7_d0,
    output logic              ior_,
    output logic              iow_
);

    state_t            state;
    logic              dir;
    logic              cmd_we;
    logic [DATA_W-1:0] cmd_wdata;
    req_idx_t          cmd_idx;
    req_idx_t          last_grant;
    logic [CNT_W-1:0]  rec_cnt;
    logic              grant_valid;
    req_idx_t          grant_idx;

    rr_arbiter2 u_arb (
        .req         ({req1, req0}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign busy  = (state != IDLE);
    assign d7_d0 = dir ? cmd_wdata : 'z;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ior_       <= 1'b1;
            iow_       <= 1'b1;
            dir        <= 1'b0;
            a3_a0      <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            rec_cnt    <= '0;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_wdata  <= '0;
            cmd_idx    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cmd_idx    <= grant_idx;
                        last_grant <= grant_idx;
                        cmd_we     <= (grant_idx == 1'b1) ? we1    : we0;
                        cmd_wdata  <= (grant_idx == 1'b1) ? wdata1 : wdata0;
                        a3_a0      <= (grant_idx == 1'b1) ? addr1  : addr0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cmd_we) begin
                        dir   <= 1'b1;
                        state <= WDRIVE;
                    end else begin
                        ior_  <= 1'b0;
                        state <= READ;
                    end
                end
                READ: begin
                    rdata <= d7_d0;
                    ior_  <= 1'b1;
                    ack0  <= (cmd_idx == 1'b0);
                    ack1  <= (cmd_idx == 1'b1);
                    state <= DONE;
                end
                WDRIVE: begin
                    iow_  <= 1'b0;
                    state <= WSTROBE;
                end
                WSTROBE: begin
                    iow_  <= 1'b1;
                    state <= WHOLD;
                end
                // data stays on the bus one cycle past the rising iow_ edge
                WHOLD: begin
                    dir   <= 1'b0;
                    ack0  <= (cmd_idx == 1'b0);
                    ack1  <= (cmd_idx == 1'b1);
                    state <= DONE;
                end
                DONE: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    rec_cnt <= CNT_W'(RECOVER_CYCLES - 1);
                    state   <= RECOVER;
                end
                RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        rec_cnt <= rec_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: two instances (RECOVER_CYCLES 1 and 4) against a transaction-timeline model.
module tb_io_bus_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst [2];
    logic       r0 [2], r1 [2], w0 [2], w1 [2];
    logic [3:0] ad0 [2], ad1 [2];
    logic [7:0] wd0 [2], wd1 [2];
    logic       k0 [2], k1 [2], by [2], ior [2], iow [2];
    logic [7:0] rd [2];
    logic [3:0] ax [2];
    logic       drv_en [2], force_drv [2];
    logic [7:0] drv_val [2];
    logic       bus_fix [2];
    logic [7:0] bus_fix_val [2];
    wire  [7:0] bus0, bus1;

    assign bus0 = (drv_en[0] || force_drv[0]) ? drv_val[0] : 'z;
    assign bus1 = (drv_en[1] || force_drv[1]) ? drv_val[1] : 'z;

    io_bus_arbiter #(.RECOVER_CYCLES(1)) dut_a (
        .clock(clock), .reset(rst[0]), .req0(r0[0]), .req1(r1[0]), .we0(w0[0]), .we1(w1[0]),
        .addr0(ad0[0]), .addr1(ad1[0]), .wdata0(wd0[0]), .wdata1(wd1[0]),
        .ack0(k0[0]), .ack1(k1[0]), .rdata(rd[0]), .busy(by[0]), .a3_a0(ax[0]),
        .d7_d0(bus0), .ior_(ior[0]), .iow_(iow[0])
    );

    io_bus_arbiter #(.RECOVER_CYCLES(4)) dut_b (
        .clock(clock), .reset(rst[1]), .req0(r0[1]), .req1(r1[1]), .we0(w0[1]), .we1(w1[1]),
        .addr0(ad0[1]), .addr1(ad1[1]), .wdata0(wd0[1]), .wdata1(wd1[1]),
        .ack0(k0[1]), .ack1(k1[1]), .rdata(rd[1]), .busy(by[1]), .a3_a0(ax[1]),
        .d7_d0(bus1), .ior_(ior[1]), .iow_(iow[1])
    );

    // Model: a transaction is described by the number of edges k since its grant edge.
    localparam int RC [2] = '{1, 4};
    bit         m_act [2], m_we [2], m_idx [2], m_last [2];
    int         m_k [2];
    logic [3:0] m_a [2];
    logic [7:0] m_wd [2], m_rd [2];
    int checks = 0;
    int errors = 0;

    function automatic int period(int u);
        return (m_we[u] ? 6 : 4) + RC[u];
    endfunction
    function automatic bit exp_dir(int u);
        return m_act[u] && m_we[u] && m_k[u] >= 2 && m_k[u] <= 4;
    endfunction
    function automatic bit exp_ior(int u);
        return !(m_act[u] && !m_we[u] && m_k[u] == 2);
    endfunction
    function automatic bit exp_iow(int u);
        return !(m_act[u] && m_we[u] && m_k[u] == 3);
    endfunction
    function automatic bit exp_ack(int u, int j);
        return m_act[u] && m_k[u] == (m_we[u] ? 5 : 3) && int'(m_idx[u]) == j;
    endfunction
    function automatic logic [7:0] bus_of(int u);
        return (u == 0) ? bus0 : bus1;
    endfunction

    task automatic model_step(int u);
        bit g;
        if (rst[u]) begin
            m_act[u] = 0; m_k[u] = 0; m_we[u] = 0; m_idx[u] = 0; m_last[u] = 1;
            m_a[u] = '0; m_wd[u] = '0; m_rd[u] = '0;
        end else if (m_act[u]) begin
            m_k[u]++;
            if (!m_we[u] && m_k[u] == 3) m_rd[u] = drv_val[u];
            if (m_k[u] == period(u)) m_act[u] = 0;
        end else if (r0[u] || r1[u]) begin
            if (r0[u] && r1[u]) g = !m_last[u];
            else g = r1[u];
            m_idx[u] = g; m_last[u] = g;
            m_we[u] = g ? w1[u] : w0[u];
            m_a[u]  = g ? ad1[u] : ad0[u];
            m_wd[u] = g ? wd1[u] : wd0[u];
            m_act[u] = 1; m_k[u] = 1;
        end
    endtask

    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) model_step(u);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Peripheral side drives the bus whenever the arbiter should not; then compare all outputs.
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            drv_en[u]  = !exp_dir(u);
            drv_val[u] = bus_fix[u] ? bus_fix_val[u] : 8'($urandom);
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d ack0", u), 32'(k0[u]), 32'(exp_ack(u, 0)));
            chk($sformatf("u%0d ack1", u), 32'(k1[u]), 32'(exp_ack(u, 1)));
            chk($sformatf("u%0d busy", u), 32'(by[u]), 32'(m_act[u]));
            chk($sformatf("u%0d ior_", u), 32'(ior[u]), 32'(exp_ior(u)));
            chk($sformatf("u%0d iow_", u), 32'(iow[u]), 32'(exp_iow(u)));
            chk($sformatf("u%0d a3_a0", u), 32'(ax[u]), 32'(m_a[u]));
            chk($sformatf("u%0d rdata", u), 32'(rd[u]), 32'(m_rd[u]));
            chk($sformatf("u%0d d7_d0", u), 32'(bus_of(u)), 32'(exp_dir(u) ? m_wd[u] : drv_val[u]));
        end
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic new_cmd(int u, int j);
        if (j == 0) begin
            r0[u] = 1; w0[u] = 1'($urandom); ad0[u] = 4'($urandom); wd0[u] = 8'($urandom);
        end else begin
            r1[u] = 1; w1[u] = 1'($urandom); ad1[u] = 4'($urandom); wd1[u] = 8'($urandom);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_t[$];
        int ack_w[$];
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1; r0[u] = 0; r1[u] = 0; w0[u] = 0; w1[u] = 0;
            ad0[u] = '0; ad1[u] = '0; wd0[u] = '0; wd1[u] = '0;
            force_drv[u] = 0; bus_fix[u] = 0; bus_fix_val[u] = '0;
        end
        repeat (2) step();
        rst[0] = 0; rst[1] = 0;
        chk("reset busy", 32'(by[0]), 0);
        chk("reset ior_", 32'(ior[0]), 1);
        chk("reset iow_", 32'(iow[0]), 1);
        chk("reset a3_a0", 32'(ax[0]), 0);
        chk("reset rdata", 32'(rd[0]), 0);

        // read of port 5 returning A7
        bus_fix[0] = 1; bus_fix_val[0] = 8'hA7;
        r0[0] = 1; w0[0] = 0; ad0[0] = 4'h5;
        step();
        chk("t1 a3_a0", 32'(ax[0]), 5);
        chk("t1 ior_ k1", 32'(ior[0]), 1);
        step();
        chk("t1 ior_ k2", 32'(ior[0]), 0);
        step();
        chk("t1 ack0 k3", 32'(k0[0]), 1);
        chk("t1 rdata", 32'(rd[0]), 32'h A7);
        chk("t1 ior_ k3", 32'(ior[0]), 1);
        r0[0] = 0;
        step();
        chk("t1 ack0 k4", 32'(k0[0]), 0);
        step();
        chk("t1 idle k5", 32'(by[0]), 0);
        bus_fix[0] = 0;

        // write of 3C to port C from requester 1
        r1[0] = 1; w1[0] = 1; ad1[0] = 4'hC; wd1[0] = 8'h3C;
        step();
        chk("t2 iow_ k1", 32'(iow[0]), 1);
        step();
        chk("t2 bus k2", 32'(bus0), 32'h3C);
        chk("t2 iow_ k2", 32'(iow[0]), 1);
        step();
        chk("t2 iow_ k3", 32'(iow[0]), 0);
        chk("t2 bus k3", 32'(bus0), 32'h3C);
        step();
        chk("t2 iow_ k4", 32'(iow[0]), 1);
        chk("t2 bus k4", 32'(bus0), 32'h3C);
        step();
        chk("t2 ack1 k5", 32'(k1[0]), 1);
        chk("t2 bus released", 32'(bus0), 32'(drv_val[0]));
        r1[0] = 0;
        repeat (2) step();
        chk("t2 idle k7", 32'(by[0]), 0);

        // tie from reset: grants alternate 0,1,0,1 five cycles apart
        rst[0] = 1; step(); rst[0] = 0;
        r0[0] = 1; w0[0] = 0; ad0[0] = 4'h1;
        r1[0] = 1; w1[0] = 0; ad1[0] = 4'h2;
        for (int cyc = 1; cyc <= 40 && ack_t.size() < 4; cyc++) begin
            step();
            if (k0[0]) begin ack_t.push_back(cyc); ack_w.push_back(0); end
            if (k1[0]) begin ack_t.push_back(cyc); ack_w.push_back(1); end
        end
        r0[0] = 0; r1[0] = 0;
        chk("t3 ack count", 32'(ack_t.size()), 4);
        if (ack_t.size() > 0) chk("t3 first ack", 32'(ack_t[0]), 3);
        for (int i = 0; i < ack_t.size(); i++) begin
            chk($sformatf("t3 grant %0d", i), 32'(ack_w[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("t3 spacing %0d", i), 32'(ack_t[i] - ack_t[i-1]), 5);
        end
        repeat (6) step();

        // back-to-back writes with RECOVER_CYCLES 4
        ack_t.delete();
        r0[1] = 1; w0[1] = 1; ad0[1] = 4'h3; wd0[1] = 8'h11;
        for (int cyc = 1; cyc <= 60 && ack_t.size() < 3; cyc++) begin
            step();
            if (k0[1]) begin
                ack_t.push_back(cyc);
                wd0[1] = wd0[1] + 8'h22;
            end
        end
        r0[1] = 0;
        chk("t4 ack count", 32'(ack_t.size()), 3);
        if (ack_t.size() > 0) chk("t4 first ack", 32'(ack_t[0]), 5);
        for (int i = 1; i < ack_t.size(); i++)
            chk($sformatf("t4 spacing %0d", i), 32'(ack_t[i] - ack_t[i-1]), 10);
        repeat (12) step();

        // reset while iow_ is low
        r0[0] = 1; w0[0] = 1; ad0[0] = 4'h7; wd0[0] = 8'h9C;
        repeat (3) step();
        chk("t5 iow_ low", 32'(iow[0]), 0);
        rst[0] = 1; r0[0] = 0; force_drv[0] = 1;
        #1;
        chk("t5 iow_ released", 32'(iow[0]), 1);
        chk("t5 ior_", 32'(ior[0]), 1);
        chk("t5 busy", 32'(by[0]), 0);
        chk("t5 no ack", 32'(k0[0]), 0);
        chk("t5 bus tristate", 32'(bus0), 32'(drv_val[0]));
        step();
        rst[0] = 0; force_drv[0] = 0;
        bus_fix[0] = 1; bus_fix_val[0] = 8'h5E;
        r0[0] = 1; w0[0] = 0; ad0[0] = 4'hA;
        repeat (3) step();
        chk("t5 read ack0", 32'(k0[0]), 1);
        chk("t5 read rdata", 32'(rd[0]), 32'h5E);
        r0[0] = 0; bus_fix[0] = 0;
        repeat (3) step();

        // requester drops req during WSTROBE
        r0[0] = 1; w0[0] = 1; ad0[0] = 4'h2; wd0[0] = 8'h6B;
        repeat (3) step();
        r0[0] = 0;
        repeat (2) step();
        chk("t6 ack0", 32'(k0[0]), 1);
        step();
        chk("t6 recover busy", 32'(by[0]), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t6 idle %0d", i), 32'(by[0]), 0);
        end

        // random requesters obeying the hold-until-ack rule
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                for (int j = 0; j < 2; j++) begin
                    if ((j == 0) ? r0[u] : r1[u]) begin
                        if (exp_ack(u, j)) begin
                            if ($urandom_range(1, 0) == 1) new_cmd(u, j);
                            else if (j == 0) r0[u] = 0;
                            else r1[u] = 0;
                        end
                    end else if ($urandom_range(9, 0) < 3) begin
                        new_cmd(u, j);
                    end
                end
            end
        end
        for (int u = 0; u < 2; u++) begin r0[u] = 0; r1[u] = 0; end
        repeat (25) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
